dco_id_counter: RTL and testbench

DCO_ID_COUNTER -- requirements
Module: dco_id_counter

---
 rtl/dco_id_counter.sv | 134 +++++++++++++
 tb/tb_dco_id_counter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dco_id_counter.sv
// Increment/decrement digital controlled oscillator for a digital PLL.
// A loop filter issues carry (advance) and borrow (retard) requests; each
// one shortens or stretches a single id_out half-period by one clk. id_out
// is then divided by N_DIV to produce dco_signal for the phase detector.
module dco_id_counter #(
  parameter int N_DIV = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic carry,
  input  logic borrow,
  output logic id_out,
  output logic dco_signal,
  output logic req_dropped
);

  localparam int HALF_DIV = N_DIV / 2;
  localparam int CW       = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  // Request edge-detect registers
  logic          carry_q, borrow_q;
  // Pending correction flags
  logic          carry_pend_q, carry_pend_d;
  logic          borrow_pend_q, borrow_pend_d;
  logic          req_dropped_q, req_dropped_d;
  // Half-period counter and current half-period length (1, 2 or 3 clk)
  logic [1:0]    hp_q, hp_d;
  logic [1:0]    len_q, len_d;
  logic          id_out_q, id_out_d;
  logic          id_prev_q;
  // Feedback divider
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dco_q, dco_d;

  logic carry_req, borrow_req;
  logic carry_only_req, borrow_only_req;
  logic toggle;
  logic both_pend;
  logic consume_carry, consume_borrow;
  logic clear_carry, clear_borrow;
  logic drop_carry, drop_borrow;
  logic id_rise, div_wrap;

  // A request is a rising level, so a held-high input counts only once.
  // Simultaneous carry and borrow requests cancel each other outright.
  assign carry_req       = carry & ~carry_q;
  assign borrow_req      = borrow & ~borrow_q;
  assign carry_only_req  = carry_req & ~borrow_req;
  assign borrow_only_req = borrow_req & ~carry_req;

  // The half-period ends when hp reaches L-1; a correction is taken only here,
  // which limits corrections to one per half-period.
  assign toggle         = (hp_q == (len_q - 2'd1));
  // Opposing corrections both pending are mutually cancelling.
  assign both_pend      = carry_pend_q & borrow_pend_q;
  assign consume_carry  = toggle & carry_pend_q & ~borrow_pend_q;
  assign consume_borrow = toggle & borrow_pend_q & ~carry_pend_q;
  assign clear_carry    = consume_carry | both_pend;
  assign clear_borrow   = consume_borrow | both_pend;
  // A fresh request beats a same-edge clear, so only a still-held flag drops.
  assign drop_carry     = carry_only_req & carry_pend_q & ~clear_carry;
  assign drop_borrow    = borrow_only_req & borrow_pend_q & ~clear_borrow;

  // Rising id_out seen from registered state: no derived clock is needed.
  assign id_rise  = id_out_q & ~id_prev_q;
  assign div_wrap = id_rise & (cnt_q == CW'(HALF_DIV - 1));

  // Next-state computation for pending flags, oscillator and divider
  always_comb begin
    carry_pend_d  = carry_only_req | (carry_pend_q & ~clear_carry);
    borrow_pend_d = borrow_only_req | (borrow_pend_q & ~clear_borrow);
    req_dropped_d = req_dropped_q | drop_carry | drop_borrow;

    hp_d     = hp_q + 2'd1;
    len_d    = len_q;
    id_out_d = id_out_q;
    if (toggle) begin
      hp_d     = 2'd0;
      id_out_d = ~id_out_q;
      if (consume_carry) begin
        len_d = 2'd1;
      end else if (consume_borrow) begin
        len_d = 2'd3;
      end else begin
        len_d = 2'd2;
      end
    end

    cnt_d = cnt_q;
    dco_d = dco_q;
    if (id_rise) begin
      if (div_wrap) begin
        cnt_d = '0;
        dco_d = ~dco_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carry_q       <= 1'b0;
      borrow_q      <= 1'b0;
      carry_pend_q  <= 1'b0;
      borrow_pend_q <= 1'b0;
      req_dropped_q <= 1'b0;
      hp_q          <= 2'd0;
      len_q         <= 2'd2;
      id_out_q      <= 1'b0;
      id_prev_q     <= 1'b0;
      cnt_q         <= '0;
      dco_q         <= 1'b0;
    end else begin
      carry_q       <= carry;
      borrow_q      <= borrow;
      carry_pend_q  <= carry_pend_d;
      borrow_pend_q <= borrow_pend_d;
      req_dropped_q <= req_dropped_d;
      hp_q          <= hp_d;
      len_q         <= len_d;
      id_out_q      <= id_out_d;
      id_prev_q     <= id_out_q;
      cnt_q         <= cnt_d;
      dco_q         <= dco_d;
    end
  end

  assign id_out      = id_out_q;
  assign dco_signal  = dco_q;
  assign req_dropped = req_dropped_q;

endmodule

// File: tb/tb_dco_id_counter.sv
// Scoreboard bench for dco_id_counter. A timeline model predicts the clk edge
// of every id_out and dco_signal transition and of the req_dropped rise; a
// negedge monitor pops and compares whenever the DUT output actually changes.
module tb_dco_id_counter;

  localparam int N_DIV    = 8;
  localparam int HALF_DIV = N_DIV / 2;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic carry  = 1'b0;
  logic borrow = 1'b0;
  logic id_out, dco_signal, req_dropped;

  dco_id_counter #(.N_DIV(N_DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .carry      (carry),
    .borrow     (borrow),
    .id_out     (id_out),
    .dco_signal (dco_signal),
    .req_dropped(req_dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    int t;
    bit lvl;
  } ev_t;
  typedef ev_t evq_t[$];

  evq_t id_q, dco_q, drop_q;
  int n_checks = 0;
  int n_fail   = 0;

  // Timeline model state: t is the number of clk edges since reset release.
  int t, next_toggle, rises, len;
  bit m_id, m_dco, m_cp, m_bp, m_drop, prev_c, prev_b;
  bit creq, breq, cp0, bp0, cons_c, cons_b, both;
  bit last_id, last_dco, last_drop;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (edge %0d)", name, act, exp, t);
    end
  endtask

  task automatic note_drop();
    if (!m_drop) drop_q.push_back('{t, 1'b1});
    m_drop = 1'b1;
  endtask

  // Reference model: half-period lengths chosen from the correction rules,
  // transitions recorded as absolute edge times.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      t = 0; next_toggle = 2; rises = 0;
      m_id = 0; m_dco = 0; m_cp = 0; m_bp = 0; m_drop = 0;
      prev_c = 0; prev_b = 0;
      id_q.delete(); dco_q.delete(); drop_q.delete();
      id_q.push_back('{2, 1'b1});
    end else begin
      t++;
      creq = carry && !prev_c;
      breq = borrow && !prev_b;
      prev_c = carry;
      prev_b = borrow;
      cp0 = m_cp; bp0 = m_bp;
      cons_c = 0; cons_b = 0;
      if (t == next_toggle) begin
        m_id = !m_id;
        if (cp0 && !bp0) begin len = 1; cons_c = 1; end
        else if (bp0 && !cp0) begin len = 3; cons_b = 1; end
        else len = 2;
        next_toggle = t + len;
        id_q.push_back('{next_toggle, !m_id});
        if (m_id) begin
          rises++;
          if (rises == HALF_DIV) begin
            rises = 0;
            m_dco = !m_dco;
            dco_q.push_back('{t + 1, m_dco});
          end
        end
      end
      both = cp0 && bp0;
      if (cons_c || both) m_cp = 0;
      if (cons_b || both) m_bp = 0;
      if (creq && !breq) begin
        if (m_cp) note_drop();
        m_cp = 1;
      end
      if (breq && !creq) begin
        if (m_bp) note_drop();
        m_bp = 1;
      end
    end
  end

  task automatic mon(input string name, ref evq_t q, input logic cur, ref bit last);
    ev_t e;
    if (cur !== last) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s unexpected change: actual %0d required no change (edge %0d)", name, cur, t);
      end else begin
        e = q.pop_front();
        chk({name, " edge"}, t, e.t);
        chk({name, " level"}, int'(cur), int'(e.lvl));
      end
      last = cur;
    end else if (q.size() > 0 && q[0].t <= t) begin
      e = q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s missed change: actual none required level %0d at edge %0d", name, e.lvl, e.t);
    end
  endtask

  // Monitor: compares observed transitions against the scoreboard queues
  always @(negedge clk) begin
    if (reset) begin
      last_id = 0; last_dco = 0; last_drop = 0;
    end else begin
      mon("id_out", id_q, id_out, last_id);
      mon("dco_signal", dco_q, dco_signal, last_dco);
      mon("req_dropped", drop_q, req_dropped, last_drop);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input bit c, input bit b);
    carry = c; borrow = b;
    @(negedge clk);
    carry = 0; borrow = 0;
  endtask

  initial begin
    int k;
    reset = 1;
    idle(3);
    chk("reset id_out", id_out, 0);
    chk("reset dco_signal", dco_signal, 0);
    chk("reset req_dropped", req_dropped, 0);
    reset = 0;
    idle(80);                                   // free run
    pulse(1, 0); idle(30);                      // single carry
    carry = 1; idle(20); carry = 0; idle(30);   // carry held high
    pulse(0, 1); idle(30);                      // single borrow
    repeat (20) begin pulse(0, 1); idle(4); end // borrow every period
    idle(30);
    pulse(1, 1); idle(30);                      // simultaneous requests
    chk("no drop after directed runs", req_dropped, 0);

    // Two carry pulses 2 clk apart inside a borrow-stretched half-period
    reset = 1; idle(2); reset = 0;
    idle(2);
    borrow = 1; @(negedge clk);
    borrow = 0; carry = 1; @(negedge clk);
    carry = 0;
    chk("drop before second carry", req_dropped, 0);
    @(negedge clk);
    carry = 1; @(negedge clk);
    carry = 0;
    chk("drop after second carry", req_dropped, 1);
    idle(20);

    // Asynchronous reset while id_out is high
    k = 0;
    while (id_out !== 1'b1 && k < 10) begin @(negedge clk); k++; end
    chk("id_out high before reset", id_out, 1);
    #2 reset = 1;
    #1;
    chk("async reset id_out", id_out, 0);
    chk("async reset dco_signal", dco_signal, 0);
    chk("async reset req_dropped", req_dropped, 0);
    idle(2);
    reset = 0;

    // Randomized requests
    repeat (1500) begin
      @(negedge clk);
      carry  = ($urandom_range(0, 5) == 0);
      borrow = ($urandom_range(0, 5) == 0);
    end
    carry = 0; borrow = 0;
    idle(40);
    chk("final req_dropped", req_dropped, int'(m_drop));
    chk("one toggle outstanding", id_q.size(), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
